// File: rtl/sha256_compress_core.sv
// Iterative SHA-256 compression core: one round per accepted schedule word, 64 rounds per block.
// Optional round trace ports are enabled by defining SHA_ROUND_TRACE_EN.
module sha256_compress_core #(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned BLK_W  = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [255:0]       h_in_i,
  input  logic [BLK_W-1:0]   block_in_i,
  input  logic               w_valid_i,
  input  logic [31:0]        w_data_i,
  output logic               w_ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [255:0]       state_out_o,
  output logic [31:0]        e_out_o,
  output logic [BLK_W-1:0]   block_out_o
`ifdef SHA_ROUND_TRACE_EN
  ,
  output logic [5:0]         dbg_round_o,
  output logic [31:0]        dbg_kt_o
`endif
);

  if (ROUNDS != 64) begin : gen_rounds_check
    $error("sha256_compress_core: ROUNDS must be 64");
  end

  localparam logic [5:0] LastRound = 6'(ROUNDS - 1);

  localparam logic [31:0] KRom [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [5:0]       t_q, t_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [31:0]      a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [31:0]      a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
  logic [255:0]     state_out_q;
  logic [31:0]      e_out_q;
  logic [BLK_W-1:0] block_out_q;

  logic        accept, finish;
  logic [31:0] s0, s1, ch, maj, t1, t2;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (finish) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode.
  always_comb begin
    w_ready_o = (state_q == StRun);
    busy_o    = (state_q != StIdle);
    done_o    = (state_q == StDone);
  end

  assign accept = w_valid_i && w_ready_o;
  assign finish = accept && (t_q == LastRound);

  always_comb begin
    s0  = ror32(a_q, 2) ^ ror32(a_q, 13) ^ ror32(a_q, 22);
    s1  = ror32(e_q, 6) ^ ror32(e_q, 11) ^ ror32(e_q, 25);
    ch  = (e_q & f_q) ^ (~e_q & g_q);
    maj = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
    t1  = h_q + s1 + ch + KRom[t_q] + w_data_i;
    t2  = s0 + maj;
  end

  always_comb begin
    {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d} = {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};
    t_d   = t_q;
    blk_d = blk_q;
    if ((state_q == StIdle) && start_i) begin
      {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d} = h_in_i;
      t_d   = '0;
      blk_d = block_in_i;
    end else if (accept) begin
      {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d} = {t1 + t2, a_q, b_q, c_q, d_q + t1, e_q, f_q, g_q};
      t_d = t_q + 6'd1; // wraps to 0 after the last round
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      t_q         <= '0;
      blk_q       <= '0;
      {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= '0;
      state_out_q <= '0;
      e_out_q     <= '0;
      block_out_q <= '0;
    end else begin
      t_q   <= t_d;
      blk_q <= blk_d;
      {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d};
      if (finish) begin
        state_out_q <= {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d};
        e_out_q     <= e_d;
        block_out_q <= blk_q;
      end
    end
  end

  assign state_out_o = state_out_q;
  assign e_out_o     = e_out_q;
  assign block_out_o = block_out_q;

`ifdef SHA_ROUND_TRACE_EN
  assign dbg_round_o = t_q;
  assign dbg_kt_o    = KRom[t_q];
`endif

endmodule
